// File: rtl/seq_addsub_pkg.sv
// Shared definitions for the sequential adder/subtractor.
//   state_t  : FSM encoding (IDLE, RUN)
//   MODE_*   : values of the sub input
//   clog2    : ceiling log2, used to size the chunk index counter
package seq_addsub_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit adder slice.
//   x, y     : CHUNK-bit addends
//   ci       : carry in
//   sum      : CHUNK-bit sum
//   co       : carry out of the top bit
//   c_msb_in : carry into the top bit (xor with co gives signed overflow)
module chunk_adder #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] sum,
  output logic             co,
  output logic             c_msb_in
);

  logic [CHUNK:0] w_full;

  assign w_full   = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
  assign sum      = w_full[CHUNK-1:0];
  assign co       = w_full[CHUNK];
  // Top-bit sum = x ^ y ^ carry_in, so the incoming carry is recovered by xor.
  assign c_msb_in = x[CHUNK-1] ^ y[CHUNK-1] ^ sum[CHUNK-1];

endmodule

// File: rtl/seq_adder_subtractor.sv
// Multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock.
//   clk, rst        : clock, asynchronous active-high reset
//   start           : request, sampled only while idle
//   sub, a, b, cin  : operation and operands, latched on the accepting edge
//   s               : result (held until the next completion)
//   cout, ovf       : raw MSB carry (sub: 1 = no borrow), signed overflow
//   zero, neg       : s == 0, s[WIDTH-1]
//   busy, done      : operation in progress, one-cycle completion pulse
module seq_adder_subtractor
  import seq_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic             busy,
  output logic             done
);

  localparam int unsigned N        = WIDTH / CHUNK;
  localparam int unsigned IDXW     = (N > 1) ? clog2(N) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);

  if ((CHUNK == 0) || (WIDTH % CHUNK != 0)) begin : g_bad_chunk
    $error("seq_adder_subtractor: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_t           r_state, w_next;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_a, r_b, r_acc;
  logic             r_carry;
  logic [WIDTH-1:0] r_s;
  logic             r_cout, r_ovf, r_zero, r_neg, r_done;

  logic [CHUNK-1:0] w_sum;
  logic             w_co, w_c_msb;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_last;

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .x        (r_a[CHUNK-1:0]),
    .y        (r_b[CHUNK-1:0]),
    .ci       (r_carry),
    .sum      (w_sum),
    .co       (w_co),
    .c_msb_in (w_c_msb)
  );

  assign w_last = (r_idx == IDX_LAST);

  // Operands shift right so the live chunk is always at bit 0; sum chunks
  // enter the partial result from the top, so after N cycles chunk 0 sits
  // at the bottom and the word is in place.
  always_comb begin
    w_acc_next = r_acc >> CHUNK;
    w_acc_next[WIDTH-1 -: CHUNK] = w_sum;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= (sub == MODE_SUB) ? ~b : b;
            r_carry <= (sub == MODE_SUB) ? ~cin : cin;
            r_idx   <= '0;
            r_acc   <= '0;
          end
        end
        RUN: begin
          r_a     <= r_a >> CHUNK;
          r_b     <= r_b >> CHUNK;
          r_carry <= w_co;
          r_acc   <= w_acc_next;
          r_idx   <= r_idx + IDXW'(1);
          if (w_last) begin
            r_s    <= w_acc_next;
            r_cout <= w_co;
            r_ovf  <= w_c_msb ^ w_co;
            r_zero <= (w_acc_next == '0);
            r_neg  <= w_acc_next[WIDTH-1];
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state == RUN);
  assign s    = r_s;
  assign cout = r_cout;
  assign ovf  = r_ovf;
  assign zero = r_zero;
  assign neg  = r_neg;
  assign done = r_done;

endmodule

// File: tb/tb_seq_adder_subtractor.sv
// Self-checking bench for seq_adder_subtractor (WIDTH=32, CHUNK=8).
module tb_seq_adder_subtractor;
  import seq_addsub_pkg::*;

  localparam int unsigned W = 32;
  localparam int unsigned NCYC = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] s;
  logic         cout, ovf, zero, neg, busy, done;

  int           n_total = 0;
  int           n_bad = 0;
  int           cyc = 0;
  int           last_done_cyc = 0;
  logic [W-1:0] prev_s = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_adder_subtractor #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .s(s), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg),
    .busy(busy), .done(done)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operation's meaning.
  function automatic void ref_op(input logic op, input logic [W-1:0] xa, input logic [W-1:0] xb,
                                 input logic xc, output logic [W-1:0] rs, output logic rc,
                                 output logic ro, output logic rz, output logic rn);
    longint ua, ub, uc, ur, sa, sb, sr;
    ua = longint'({32'b0, xa});
    ub = longint'({32'b0, xb});
    uc = longint'(xc);
    sa = longint'($signed(xa));
    sb = longint'($signed(xb));
    if (op == MODE_SUB) begin
      ur = ua - ub - uc;
      sr = sa - sb - uc;
      rc = (ur >= 0);
    end else begin
      ur = ua + ub + uc;
      sr = sa + sb + uc;
      rc = (ur > 64'sd4294967295);
    end
    rs = ur[W-1:0];
    ro = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    rz = (rs == '0);
    rn = rs[W-1];
  endfunction

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      check_eq("idle_done", done, 0);
      check_eq("idle_busy", busy, 0);
      check_eq("idle_s", s, prev_s);
    end
  endtask

  // Issues one op and follows it to completion. Returns #1 after the done
  // edge, so an immediately following call starts in the done cycle.
  task automatic run_op(input logic op, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic xc, input bit spam);
    logic [W-1:0] es;
    logic         ec, eo, ez, en;
    int unsigned  lat;
    ref_op(op, xa, xb, xc, es, ec, eo, ez, en);
    @(negedge clk);
    start = 1'b1; sub = op; a = xa; b = xb; cin = xc;
    @(posedge clk);
    #1;
    check_eq("busy_accept", busy, 1);
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      start = spam && (lat < 2);
      a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
      @(posedge clk);
      #1;
      lat++;
      if (done !== 1'b1) begin
        check_eq("busy_run", busy, 1);
        check_eq("s_stable", s, prev_s);
      end
    end
    start = 1'b0;
    last_done_cyc = cyc;
    check_eq("latency", 64'(lat), 64'(NCYC));
    check_eq("busy_end", busy, 0);
    check_eq("s", s, es);
    check_eq("cout", cout, ec);
    check_eq("ovf", ovf, eo);
    check_eq("zero", zero, ez);
    check_eq("neg", neg, en);
    prev_s = es;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1;
    logic [W-1:0] pick [4];
    logic [W-1:0] ra, rb;

    #2 rst = 1'b1;
    #1;
    check_eq("rst_s", s, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_flags", {cout, ovf, zero, neg}, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    idle(1);

    run_op(MODE_ADD, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0);
    check_eq("plan_add_s", s, 64'hFFFFFFFE);
    idle(1);
    run_op(MODE_ADD, 32'h7FFFFFFF, 32'h00000001, 1'b0, 0);
    check_eq("plan_ovf", ovf, 1);
    idle(1);
    run_op(MODE_SUB, 32'h00000005, 32'h00000007, 1'b0, 0);
    check_eq("plan_borrow", cout, 0);
    idle(1);
    run_op(MODE_SUB, 32'h80000000, 32'h00000001, 1'b0, 0);
    idle(1);
    run_op(MODE_SUB, 32'h12345678, 32'h12345678, 1'b0, 0);
    check_eq("plan_zero", zero, 1);
    idle(1);
    run_op(MODE_SUB, 32'h12345678, 32'h12345678, 1'b1, 0);
    check_eq("plan_chain_s", s, 64'hFFFFFFFF);
    idle(1);

    // starts during busy are ignored
    run_op(MODE_ADD, 32'h00001000, 32'h00000234, 1'b1, 1);
    idle(2);

    // back-to-back: second op starts in the done cycle
    run_op(MODE_ADD, 32'h0000FFFF, 32'h00000001, 1'b0, 0);
    t1 = last_done_cyc;
    run_op(MODE_SUB, 32'h00000010, 32'h00000020, 1'b1, 0);
    check_eq("b2b_gap", 64'(last_done_cyc - t1), 64'(NCYC + 1));
    idle(1);

    // reset in the middle of an operation
    @(negedge clk);
    start = 1'b1; sub = MODE_ADD; a = 32'h11111111; b = 32'h22222222; cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_done", done, 0);
    check_eq("midrst_s", s, 0);
    check_eq("midrst_flags", {cout, ovf, zero, neg}, 0);
    prev_s = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    idle(6);
    run_op(MODE_ADD, 32'h00000001, 32'h00000001, 1'b0, 0);
    check_eq("post_rst_s", s, 64'h2);
    idle(1);

    pick[0] = 32'hFFFFFFFF;
    pick[1] = 32'h80000000;
    pick[2] = 32'h7FFFFFFF;
    pick[3] = 32'h00000000;
    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 3)] : W'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 3)] : W'($urandom);
      if ($urandom_range(0, 5) == 0) rb = ra;
      run_op(1'($urandom), ra, rb, 1'($urandom), $urandom_range(0, 3) == 0);
      idle($urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
